// File: rtl/regfile_wb_sched_pkg.sv
// Shared register-bus widths, write-enable levels and the zero word used
// by the write-back scheduler.
package regfile_wb_sched_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_ADDR_BUS = REG_NUM_LOG2;
  localparam int REG_NUM      = 32;
  localparam int WB_REQ_NUM   = 3;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// N-way round-robin arbiter with one-hot grant; owns the rotation pointer.
// With fixed0_i set, requester 0 always wins and never moves the pointer.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  input  logic         fixed0_i,
  output logic [N-1:0] gnt_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx;

  // Scan offsets from far to near so the nearest requester after ptr wins.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_o   = '0;
    gnt_idx = '0;
    if (fixed0_i && req_i[0]) begin
      gnt_o[0] = 1'b1;
    end else begin
      for (int k = N; k >= 1; k--) begin
        j = int'(ptr_q) + k;
        if (j >= N) j = j - N;
        jj = IDX_W'(j);
        if (req_i[jj] && !(fixed0_i && (j == 0))) begin
          gnt_o     = '0;
          gnt_o[jj] = 1'b1;
          gnt_idx   = jj;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && !(fixed0_i && gnt_o[0])) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IDX_W'(N - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler sharing the register-file write port among NUM_REQ
// producers, with a busy scoreboard. RF_WB_FIXED_PRIO_EN gives producer 0 strict priority.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int NUM_REQ = WB_REQ_NUM,
  parameter int ADDR_W  = REG_ADDR_BUS,
  parameter int DATA_W  = REG_BUS
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      rsv_valid_i,
  input  logic [ADDR_W-1:0]         rsv_addr_i,
  output logic                      rsv_ready_o,
  input  logic                      flush_i,
  input  logic [ADDR_W-1:0]         q_addr1_i,
  input  logic [ADDR_W-1:0]         q_addr2_i,
  output logic                      q_busy1_o,
  output logic                      q_busy2_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         waddr_o,
  output logic [DATA_W-1:0]         wdata_o,
  output logic [REG_NUM-1:0]        busy_vec_o
);

`ifdef RF_WB_FIXED_PRIO_EN
  localparam logic FIXED0 = 1'b1;
`else
  localparam logic FIXED0 = 1'b0;
`endif

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [REG_NUM-1:0] busy_q, busy_d;

  logic               xfer;
  logic               clr_valid;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (xfer),
    .fixed0_i  (FIXED0),
    .gnt_o     (req_ready_o)
  );

  assign xfer = |(req_valid_i & req_ready_o);

  always_comb begin
    wb_addr = '0;
    wb_data = ZERO_WORD[DATA_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_o[i]) begin
        wb_addr = req_addr_i[i*ADDR_W +: ADDR_W];
        wb_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register 0 is hardwired, so a write-back to it never clears anything.
  assign clr_valid = xfer && (wb_addr != '0);

  assign rsv_ready_o = !flush_i &&
                       ((rsv_addr_i == '0) || !busy_q[rsv_addr_i] ||
                        (clr_valid && (wb_addr == rsv_addr_i)));

  assign q_busy1_o = busy_q[q_addr1_i] && (q_addr1_i != '0) &&
                     !(clr_valid && (wb_addr == q_addr1_i));
  assign q_busy2_o = busy_q[q_addr2_i] && (q_addr2_i != '0) &&
                     !(clr_valid && (wb_addr == q_addr2_i));

  // Set is applied after clear so a same-cycle reserve keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[wb_addr] = 1'b0;
    if (rsv_valid_i && rsv_ready_o && (rsv_addr_i != '0)) busy_d[rsv_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_comb begin
    we_d    = clr_valid ? WRITE_ENABLE : WRITE_DISABLE;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      waddr_d = wb_addr;
      wdata_d = wb_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= WRITE_DISABLE;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: a reference model predicts grants,
// scoreboard queries and the registered write port each cycle.
module tb_regfile_wb_sched;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ready;
  logic              flush;
  logic [AW-1:0]     q1, q2;
  logic              q_busy1, q_busy2;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [31:0]       busy_vec;

  logic [AW-1:0]     ra [N];
  logic [DW-1:0]     rd [N];

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
  end

  regfile_wb_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
    .flush_i(flush), .q_addr1_i(q1), .q_addr2_i(q2),
    .q_busy1_o(q_busy1), .q_busy2_o(q_busy2),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .busy_vec_o(busy_vec)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [31:0]   busy;
  } exp_t;

  exp_t          sbq[$];
  int            ptr_m;
  logic [31:0]   busy_m;
  logic [AW-1:0] waddr_m;
  logic [DW-1:0] wdata_m;

  function automatic int model_grant(input logic [N-1:0] v, input int p);
`ifdef RF_WB_FIXED_PRIO_EN
    if (v[0]) return 0;
    for (int k = 1; k <= N; k++)
      if (((p + k) % N) != 0 && v[(p + k) % N]) return (p + k) % N;
`else
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m   = N - 1;
    busy_m  = '0;
    waddr_m = '0;
    wdata_m = '0;
    sbq.delete();
  endtask

  // Called at posedge+1 with inputs already applied; ends at the next posedge+1.
  task automatic step();
    int            g;
    logic          x;
    logic [AW-1:0] ga;
    logic          rr_e, qb1_e, qb2_e;
    logic [N-1:0]  gnt_e;
    exp_t          e;
    #1;
    g     = model_grant(req_valid, ptr_m);
    x     = (g >= 0);
    ga    = x ? ra[g] : '0;
    gnt_e = '0;
    if (x) gnt_e[g] = 1'b1;
    qb1_e = busy_m[q1] && (q1 != 0) && !(x && ga != 0 && ga == q1);
    qb2_e = busy_m[q2] && (q2 != 0) && !(x && ga != 0 && ga == q2);
    rr_e  = !flush && ((rsv_addr == 0) || !busy_m[rsv_addr] ||
                       (x && ga != 0 && ga == rsv_addr));
    chk("req_ready", 64'(req_ready), 64'(gnt_e));
    chk("q_busy1",   64'(q_busy1),   64'(qb1_e));
    chk("q_busy2",   64'(q_busy2),   64'(qb2_e));
    chk("rsv_ready", 64'(rsv_ready), 64'(rr_e));
    if (x) begin
      waddr_m = ga;
      wdata_m = rd[g];
`ifdef RF_WB_FIXED_PRIO_EN
      if (g != 0) ptr_m = g;
`else
      ptr_m = g;
`endif
    end
    if (x && ga != 0) busy_m[ga] = 1'b0;
    if (rsv_valid && rr_e && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
    if (flush) busy_m = '0;
    e.we   = x && (ga != 0);
    e.a    = waddr_m;
    e.d    = wdata_m;
    e.busy = busy_m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      e = sbq.pop_front();
      chk("we",       64'(we),       64'(e.we));
      chk("waddr",    64'(waddr),    64'(e.a));
      chk("wdata",    64'(wdata),    64'(e.d));
      chk("busy_vec", 64'(busy_vec), 64'(e.busy));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_we",    64'(we),       64'(0));
    chk("rst_waddr", 64'(waddr),    64'(0));
    chk("rst_wdata", 64'(wdata),    64'(0));
    chk("rst_busy",  64'(busy_vec), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    flush     = 1'b0;
    q1        = '0;
    q2        = '0;
    for (int i = 0; i < N; i++) begin
      ra[i] = '0;
      rd[i] = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single producer 1 writing 0xAA to register 5
    req_valid = 3'b010; ra[1] = 5; rd[1] = 32'h0000_00AA;
    step();
    req_valid = '0;
    step();

    // All producers requesting continuously from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) begin
      ra[i] = AW'(i + 1);
      rd[i] = 32'h100 + i;
    end
    req_valid = 3'b111;
    repeat (6) step();
    req_valid = '0;
    step();

    // Reserve 7, then write it back while decode queries it
    rsv_valid = 1'b1; rsv_addr = 7; q1 = 7; q2 = 3;
    step();
    rsv_valid = 1'b0;
    step();
    req_valid = 3'b001; ra[0] = 7; rd[0] = 32'h77;
    step();
    req_valid = '0;
    step();

    // Reserve conflicts: blocked while busy, accepted on the clearing cycle
    rsv_valid = 1'b1; rsv_addr = 7;
    step();
    step();
    req_valid = 3'b010; ra[1] = 7; rd[1] = 32'h1234_5678;
    step();
    req_valid = '0; rsv_valid = 1'b0;
    step();

    // Register 0 is never written nor tracked
    req_valid = 3'b100; ra[2] = 0; rd[2] = 32'hFFFF_FFFF;
    step();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 0; q1 = 0; q2 = 0;
    step();

    // Flush with a concurrent reservation and write-back
    rsv_addr = 3; step();
    rsv_addr = 9; step();
    rsv_valid = 1'b0; q1 = 3; q2 = 9;
    step();
    flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 12;
    req_valid = 3'b001; ra[0] = 4; rd[0] = 32'hCAFE;
    step();
    flush = 1'b0; rsv_valid = 1'b0; req_valid = '0;
    step();

    // Asynchronous reset in the middle of back-to-back write-backs
    rsv_valid = 1'b1; rsv_addr = 11;
    for (int i = 0; i < N; i++) begin
      ra[i] = AW'(20 + i);
      rd[i] = 32'hA000 + i;
    end
    req_valid = 3'b111;
    step();
    rsv_valid = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_we",   64'(we),       64'(0));
    chk("midrst_busy", 64'(busy_vec), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_gnt", 64'(req_ready), 64'(3'b001));
    step();
    repeat (2) step();
    req_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
